// File: rtl/clock_divider_pkg.sv
// Shared constants and encodings for the multi-channel clock divider.
package clock_divider_pkg;

    localparam int unsigned CD_CNT_W       = 16;
    localparam int unsigned CD_DIV_DEFAULT = 25;
    localparam int unsigned CD_HP_MIN      = 1;

    typedef enum logic [1:0] {
        TICK_NONE = 2'b00,
        TICK_RISE = 2'b01,
        TICK_FALL = 2'b10
    } tick_e;

endpackage

// File: rtl/clock_divider_chan.sv
// One divider channel: half-period counter, active/pending half-period,
// rise/fall strobes and a load acknowledge.
// Optional phase-alignment input sync_i exists only when CLOCK_DIVIDER_SYNC_EN is defined.
module clock_divider_chan
    import clock_divider_pkg::*;
#(
    parameter int unsigned CNT_W       = CD_CNT_W,
    parameter int unsigned DIV_DEFAULT = CD_DIV_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
`ifdef CLOCK_DIVIDER_SYNC_EN
    input  logic             sync_i,
`endif
    input  logic [CNT_W-1:0] half_period_i,
    input  logic             load_i,
    output logic             clk_div_o,
    output logic             rise_tick_o,
    output logic             fall_tick_o,
    output logic             load_ack_o
);

    localparam logic [CNT_W-1:0] HP_MIN   = CNT_W'(CD_HP_MIN);
    localparam logic [CNT_W-1:0] HP_RESET = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hp_act_q, hp_act_d;
    logic [CNT_W-1:0] hp_pend_q, hp_pend_d;
    logic             pend_q, pend_d;
    logic             clk_div_q, clk_div_d;
    logic             rise_q, fall_q, ack_q;
    logic             ack_d;
    tick_e            tick_d;

    logic restart;
    logic terminal;
    logic apply;

    // A restart (disable or sync) parks the channel low with the counter cleared.
`ifdef CLOCK_DIVIDER_SYNC_EN
    assign restart = ~en_i | sync_i;
`else
    assign restart = ~en_i;
`endif

    // hp_act_q is never below 1, so the subtraction cannot underflow.
    assign terminal = (cnt_q == (hp_act_q - HP_MIN));

    // A pending value is only taken at a falling boundary or while parked,
    // so a half-period never changes mid-period.
    assign apply = pend_q & (restart | (terminal & clk_div_q));

    // Next-state logic for counter, output level, ticks and half-period registers.
    always_comb begin
        cnt_d     = cnt_q;
        clk_div_d = clk_div_q;
        hp_act_d  = hp_act_q;
        hp_pend_d = hp_pend_q;
        pend_d    = pend_q;
        tick_d    = TICK_NONE;
        ack_d     = apply;

        if (restart) begin
            cnt_d     = '0;
            clk_div_d = 1'b0;
            if (clk_div_q) begin
                tick_d = TICK_FALL;
            end
        end else if (terminal) begin
            cnt_d     = '0;
            clk_div_d = ~clk_div_q;
            tick_d    = clk_div_q ? TICK_FALL : TICK_RISE;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (apply) begin
            hp_act_d = hp_pend_q;
            pend_d   = 1'b0;
        end

        // A load coinciding with a boundary lands after the apply above, so it
        // waits for the following boundary.
        if (load_i) begin
            hp_pend_d = (half_period_i == '0) ? HP_MIN : half_period_i;
            pend_d    = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            hp_act_q  <= HP_RESET;
            hp_pend_q <= '0;
            pend_q    <= 1'b0;
            clk_div_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hp_act_q  <= hp_act_d;
            hp_pend_q <= hp_pend_d;
            pend_q    <= pend_d;
            clk_div_q <= clk_div_d;
            rise_q    <= (tick_d == TICK_RISE);
            fall_q    <= (tick_d == TICK_FALL);
            ack_q     <= ack_d;
        end
    end

    assign clk_div_o   = clk_div_q;
    assign rise_tick_o = rise_q;
    assign fall_tick_o = fall_q;
    assign load_ack_o  = ack_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel clock divider on CLK50MHZ: slices the buses and fans out
// one independent clock_divider_chan per channel.
// Define CLOCK_DIVIDER_SYNC_EN to add the sync input that phase-aligns all enabled channels.
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned CNT_W       = CD_CNT_W,
    parameter int unsigned DIV_DEFAULT = CD_DIV_DEFAULT
) (
    input  logic                      CLK50MHZ,
    input  logic                      RST,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*CNT_W-1:0] half_period,
    input  logic [CHANNELS-1:0]       load,
`ifdef CLOCK_DIVIDER_SYNC_EN
    input  logic                      sync,
`endif
    output logic [CHANNELS-1:0]       load_ack,
    output logic [CHANNELS-1:0]       clk_div,
    output logic [CHANNELS-1:0]       rise_tick,
    output logic [CHANNELS-1:0]       fall_tick
);

    // One channel per bus slice; channels share only the clock, reset and sync.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        clock_divider_chan #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_chan (
            .clk_i         (CLK50MHZ),
            .rst_ni        (RST),
            .en_i          (en[g]),
`ifdef CLOCK_DIVIDER_SYNC_EN
            .sync_i        (sync),
`endif
            .half_period_i (half_period[g*CNT_W +: CNT_W]),
            .load_i        (load[g]),
            .clk_div_o     (clk_div[g]),
            .rise_tick_o   (rise_tick[g]),
            .fall_tick_o   (fall_tick[g]),
            .load_ack_o    (load_ack[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: a timestamp-based reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_clock_divider_multi;

    localparam int CH   = 2;
    localparam int W    = 16;
    localparam int DIVD = 25;
    localparam int BUDGET = 200;

    logic                CLK50MHZ = 1'b0;
    logic                RST = 1'b0;
    logic [CH-1:0]       en = '0;
    logic [CH*W-1:0]     half_period = '0;
    logic [CH-1:0]       load = '0;
`ifdef CLOCK_DIVIDER_SYNC_EN
    logic                sync = 1'b0;
`endif
    logic [CH-1:0]       load_ack;
    logic [CH-1:0]       clk_div;
    logic [CH-1:0]       rise_tick;
    logic [CH-1:0]       fall_tick;

    int checks = 0;
    int errors = 0;

    always #5 CLK50MHZ = ~CLK50MHZ;

    clock_divider_multi #(
        .CHANNELS    (CH),
        .CNT_W       (W),
        .DIV_DEFAULT (DIVD)
    ) dut (
        .CLK50MHZ    (CLK50MHZ),
        .RST         (RST),
        .en          (en),
        .half_period (half_period),
        .load        (load),
`ifdef CLOCK_DIVIDER_SYNC_EN
        .sync        (sync),
`endif
        .load_ack    (load_ack),
        .clk_div     (clk_div),
        .rise_tick   (rise_tick),
        .fall_tick   (fall_tick)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: each channel remembers the cycle its current half-period
    // started; the next edge is due exactly hp cycles later.
    longint m_cyc = 0;
    longint m_seg [CH];
    int     m_hp  [CH];
    int     m_pv  [CH];
    bit     m_pend[CH];
    bit     m_lvl [CH];
    bit     m_rise[CH];
    bit     m_fall[CH];
    bit     m_ack [CH];
    bit     m_valid = 1'b0;

    always @(posedge CLK50MHZ) begin
        m_cyc++;
        for (int i = 0; i < CH; i++) begin
            int hp_in;
            bit was;
            bit park;
            hp_in = int'(half_period[i*W +: W]);
            was   = m_lvl[i];
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            m_ack[i]  = 1'b0;
            if (!RST) begin
                m_lvl[i]  = 1'b0;
                m_hp[i]   = DIVD;
                m_pend[i] = 1'b0;
                m_seg[i]  = m_cyc;
            end else begin
                park = !en[i];
`ifdef CLOCK_DIVIDER_SYNC_EN
                park = park || sync;
`endif
                if (park) begin
                    m_lvl[i]  = 1'b0;
                    m_fall[i] = was;
                    m_seg[i]  = m_cyc;
                    if (m_pend[i]) begin
                        m_hp[i] = m_pv[i]; m_pend[i] = 1'b0; m_ack[i] = 1'b1;
                    end
                end else if (m_cyc == m_seg[i] + longint'(m_hp[i])) begin
                    m_lvl[i]  = !was;
                    m_rise[i] = !was;
                    m_fall[i] = was;
                    m_seg[i]  = m_cyc;
                    if (was && m_pend[i]) begin
                        m_hp[i] = m_pv[i]; m_pend[i] = 1'b0; m_ack[i] = 1'b1;
                    end
                end
                if (load[i]) begin
                    m_pv[i]   = (hp_in == 0) ? 1 : hp_in;
                    m_pend[i] = 1'b1;
                end
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge CLK50MHZ) begin
        if (m_valid) begin
            for (int i = 0; i < CH; i++) begin
                check($sformatf("model ch%0d clk_div", i),   32'(clk_div[i]),   32'(m_lvl[i]));
                check($sformatf("model ch%0d rise_tick", i), 32'(rise_tick[i]), 32'(m_rise[i]));
                check($sformatf("model ch%0d fall_tick", i), 32'(fall_tick[i]), 32'(m_fall[i]));
                check($sformatf("model ch%0d load_ack", i),  32'(load_ack[i]),  32'(m_ack[i]));
            end
        end
    end

    // Count sampled cycles until the chosen strobe of a channel is seen.
    task automatic wait_strobe(input int ch, input int kind, output int n);
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < BUDGET) begin
            @(negedge CLK50MHZ);
            n++;
            case (kind)
                0:       hit = rise_tick[ch];
                1:       hit = fall_tick[ch];
                default: hit = load_ack[ch];
            endcase
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL timeout ch%0d strobe %0d after %0d cycles", ch, kind, n);
            n = -1;
        end
    endtask

    task automatic pulse_load(input int ch, input int value);
        half_period[ch*W +: W] = W'(value);
        load[ch] = 1'b1;
        @(negedge CLK50MHZ);
        load[ch] = 1'b0;
    endtask

    initial begin
        int n;
        bit ack_seen;

        // 1: reset state, then default 25/25 waveform
        en = 2'b11;
        repeat (10) @(negedge CLK50MHZ);
        check("reset clk_div",   32'(clk_div),   32'd0);
        check("reset rise_tick", 32'(rise_tick), 32'd0);
        check("reset fall_tick", 32'(fall_tick), 32'd0);
        check("reset load_ack",  32'(load_ack),  32'd0);
        RST = 1'b1;
        wait_strobe(0, 0, n);
        check("first rise ch0", n, 32'd25);
        wait_strobe(0, 1, n);
        check("high time ch0", n, 32'd25);
        wait_strobe(0, 0, n);
        check("low time ch0", n, 32'd25);

        // 2: ch1 load 3 while high; old period finishes, ack with the fall
        check("ch1 high before load", 32'(clk_div[1]), 32'd1);
        pulse_load(1, 3);
        wait_strobe(1, 1, n);
        check("ch1 fall unchanged", n, 32'd24);
        check("ch1 ack with fall", 32'(load_ack[1]), 32'd1);
        wait_strobe(1, 0, n);
        check("ch1 low 3", n, 32'd3);
        wait_strobe(1, 1, n);
        check("ch1 high 3", n, 32'd3);

        // 3: hp=1 and hp=0 both give period 2
        pulse_load(1, 1);
        wait_strobe(1, 2, n);
        wait_strobe(1, 0, n);
        check("ch1 hp1 low", n, 32'd1);
        wait_strobe(1, 1, n);
        check("ch1 hp1 high", n, 32'd1);
        pulse_load(1, 0);
        wait_strobe(1, 2, n);
        wait_strobe(1, 0, n);
        check("ch1 hp0 low", n, 32'd1);
        wait_strobe(1, 1, n);
        check("ch1 hp0 high", n, 32'd1);

        // 4: disable while high, then re-enable
        wait_strobe(0, 0, n);
        en[0] = 1'b0;
        @(negedge CLK50MHZ);
        check("disable clk_div", 32'(clk_div[0]), 32'd0);
        check("disable fall", 32'(fall_tick[0]), 32'd1);
        repeat (3) @(negedge CLK50MHZ);
        check("disabled stays low", 32'(clk_div[0]), 32'd0);
        en[0] = 1'b1;
        wait_strobe(0, 0, n);
        check("re-enable rise", n, 32'd25);

        // 5: pending load lost to reset
        ack_seen = 1'b0;
        pulse_load(0, 7);
        ack_seen |= load_ack[0];
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK50MHZ);
            ack_seen |= load_ack[0];
        end
        check("reset drops ack", 32'(ack_seen), 32'd0);
        RST = 1'b1;
        wait_strobe(0, 0, n);
        check("post reset rise", n, 32'd25);
        wait_strobe(0, 1, n);
        check("post reset high", n, 32'd25);
        wait_strobe(0, 0, n);
        check("post reset low", n, 32'd25);

`ifdef CLOCK_DIVIDER_SYNC_EN
        // 6: sync realigns channels with different half-periods
        begin
            bit a0, a1, r0, r1;
            int t0, t1;
            a0 = 1'b0; a1 = 1'b0;
            half_period = {W'(6), W'(4)};
            load = 2'b11;
            @(negedge CLK50MHZ);
            load = 2'b00;
            n = 0;
            while (!(a0 && a1) && n < BUDGET) begin
                @(negedge CLK50MHZ);
                n++;
                a0 |= load_ack[0];
                a1 |= load_ack[1];
            end
            check("sync setup acks", 32'({a0, a1}), 32'd3);
            repeat (7) @(negedge CLK50MHZ);
            sync = 1'b1;
            @(negedge CLK50MHZ);
            sync = 1'b0;
            check("sync both low", 32'(clk_div), 32'd0);
            r0 = 1'b0; r1 = 1'b0; t0 = -1; t1 = -1; n = 0;
            while (!(r0 && r1) && n < BUDGET) begin
                @(negedge CLK50MHZ);
                n++;
                if (rise_tick[0] && !r0) begin r0 = 1'b1; t0 = n; end
                if (rise_tick[1] && !r1) begin r1 = 1'b1; t1 = n; end
            end
            check("sync ch0 rise", t0, 32'd4);
            check("sync ch1 rise", t1, 32'd6);
        end
`endif

        repeat (5) @(negedge CLK50MHZ);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
